// File: rtl/input_conditioner_pkg.sv
// Shared types and defaults for the pin-conditioning front end.
// Debounce FSM state encoding and default timing parameters.
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } debounce_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_SYNC_STAGES     = 2;

endpackage

// File: rtl/debounce_bit.sv
// One conditioning channel: multi-flop synchroniser, debounce FSM with a
// saturating-free counter, and registered level/rise/fall outputs.
module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;
    logic [CW-1:0]          cnt;
    debounce_state_t        state;

    assign synced = sync[SYNC_STAGES-1];

    // The count is compared against CNT_MAX before incrementing, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            state <= STABLE_LOW;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE_LOW: begin
                    if (synced) begin
                        state <= WAIT_HIGH;
                        cnt   <= CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (!synced) begin
                        state <= STABLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= STABLE_HIGH;
                        cnt   <= '0;
                        level <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!synced) begin
                        state <= WAIT_LOW;
                        cnt   <= CNT_ONE;
                    end
                end
                WAIT_LOW: begin
                    if (synced) begin
                        state <= STABLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= STABLE_LOW;
                        cnt   <= '0;
                        level <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Board-pin front end: debounced button/switch levels and edge pulses, plus
// a downstream reset that asserts asynchronously and releases synchronously.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int SW_WIDTH        = 4
) (
    input  logic                PHYSICAL_CLOCK,
    input  logic                PHYSICAL_RESET,
    input  logic                PHYSICAL_BUTTON,
    input  logic [SW_WIDTH-1:0] PHYSICAL_SWITCH,
    output logic                RESET,
    output logic                BUTTON_LEVEL,
    output logic                BUTTON_PRESS,
    output logic                BUTTON_RELEASE,
    output logic [SW_WIDTH-1:0] SWITCH,
    output logic                SWITCH_CHANGE
);

    logic [SW_WIDTH:0]      raw_in;
    logic [SW_WIDTH:0]      lvl;
    logic [SW_WIDTH:0]      rise;
    logic [SW_WIDTH:0]      fall;
    logic [SYNC_STAGES-1:0] rst_ff;

    // Channel 0 is the button; channels 1..SW_WIDTH are the switch bits.
    assign raw_in = {PHYSICAL_SWITCH, PHYSICAL_BUTTON};

    for (genvar i = 0; i <= SW_WIDTH; i++) begin : g_chan
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_debounce (
            .clk  (PHYSICAL_CLOCK),
            .rst_n(PHYSICAL_RESET),
            .raw  (raw_in[i]),
            .level(lvl[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    // Ones are loaded asynchronously; zeros walk in one stage per edge on release.
    always_ff @(posedge PHYSICAL_CLOCK or negedge PHYSICAL_RESET) begin
        if (!PHYSICAL_RESET) begin
            rst_ff <= '1;
        end else begin
            rst_ff <= {rst_ff[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign RESET          = rst_ff[SYNC_STAGES-1];
    assign BUTTON_LEVEL   = lvl[0];
    assign BUTTON_PRESS   = rise[0];
    assign BUTTON_RELEASE = fall[0];
    assign SWITCH         = lvl[SW_WIDTH:1];
    assign SWITCH_CHANGE  = |(rise[SW_WIDTH:1] | fall[SW_WIDTH:1]);

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       PHYSICAL_RESET;
    logic       PHYSICAL_BUTTON;
    logic [3:0] PHYSICAL_SWITCH;
    logic       RESET;
    logic       BUTTON_LEVEL;
    logic       BUTTON_PRESS;
    logic       BUTTON_RELEASE;
    logic [3:0] SWITCH;
    logic       SWITCH_CHANGE;

    int vectors     = 0;
    int miscompares = 0;

    int edge_no     = 0;
    int press_cnt   = 0;
    int press_edge  = -1;
    int rel_cnt     = 0;
    int rel_edge    = -1;
    int change_cnt  = 0;
    int overlap_cnt = 0;

    input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2),
        .SW_WIDTH       (4)
    ) dut (
        .PHYSICAL_CLOCK (clk),
        .PHYSICAL_RESET (PHYSICAL_RESET),
        .PHYSICAL_BUTTON(PHYSICAL_BUTTON),
        .PHYSICAL_SWITCH(PHYSICAL_SWITCH),
        .RESET          (RESET),
        .BUTTON_LEVEL   (BUTTON_LEVEL),
        .BUTTON_PRESS   (BUTTON_PRESS),
        .BUTTON_RELEASE (BUTTON_RELEASE),
        .SWITCH         (SWITCH),
        .SWITCH_CHANGE  (SWITCH_CHANGE)
    );

    // Clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) edge_no <= edge_no + 1;

    // Pulse monitors sample on the falling edge
    always @(negedge clk) begin
        if (BUTTON_PRESS) begin
            press_cnt  <= press_cnt + 1;
            press_edge <= edge_no;
        end
        if (BUTTON_RELEASE) begin
            rel_cnt  <= rel_cnt + 1;
            rel_edge <= edge_no;
        end
        if (SWITCH_CHANGE) change_cnt <= change_cnt + 1;
        if (BUTTON_PRESS && BUTTON_RELEASE) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {24'd0, BUTTON_LEVEL, BUTTON_PRESS, BUTTON_RELEASE, SWITCH, SWITCH_CHANGE};
    endfunction

    initial begin
        int cap;
        int p0;
        int r0;
        int c0;

        // Reset asserted asynchronously before any clock edge
        PHYSICAL_RESET  = 1'b1;
        PHYSICAL_BUTTON = 1'b0;
        PHYSICAL_SWITCH = 4'd0;
        #1 PHYSICAL_RESET = 1'b0;
        #1;
        chk("reset_async_RESET", 32'(RESET), 32'd1);
        chk("reset_async_outs", outs(), 32'd0);

        // Inputs toggle while reset is held
        for (int i = 0; i < 6; i++) begin
            PHYSICAL_BUTTON = ~PHYSICAL_BUTTON;
            PHYSICAL_SWITCH = PHYSICAL_SWITCH + 4'd7;
            tick(1);
            chk("reset_hold_RESET", 32'(RESET), 32'd1);
            chk("reset_hold_outs", outs(), 32'd0);
        end
        PHYSICAL_BUTTON = 1'b0;
        PHYSICAL_SWITCH = 4'd0;
        tick(1);

        // Release between edges; a short glitch restarts the count
        PHYSICAL_RESET = 1'b1;
        tick(1);
        chk("release_edge1", 32'(RESET), 32'd1);
        PHYSICAL_RESET = 1'b0;
        #2 PHYSICAL_RESET = 1'b1;
        tick(1);
        chk("glitch_edge1", 32'(RESET), 32'd1);
        tick(1);
        chk("glitch_edge2", 32'(RESET), 32'd0);

        // Clean press
        tick(3);
        p0 = press_cnt;
        PHYSICAL_BUTTON = 1'b1;
        cap = edge_no + 1;
        tick(6);
        chk("press_level_early", 32'(BUTTON_LEVEL), 32'd0);
        chk("press_pulse_early", 32'(BUTTON_PRESS), 32'd0);
        tick(1);
        chk("press_level", 32'(BUTTON_LEVEL), 32'd1);
        chk("press_pulse", 32'(BUTTON_PRESS), 32'd1);
        tick(1);
        chk("press_pulse_end", 32'(BUTTON_PRESS), 32'd0);
        chk("press_count", 32'(press_cnt - p0), 32'd1);
        chk("press_edge", 32'(press_edge), 32'(cap + 6));

        // Clean release
        tick(3);
        r0 = rel_cnt;
        PHYSICAL_BUTTON = 1'b0;
        cap = edge_no + 1;
        tick(6);
        chk("release_level_early", 32'(BUTTON_LEVEL), 32'd1);
        tick(1);
        chk("release_level", 32'(BUTTON_LEVEL), 32'd0);
        chk("release_pulse", 32'(BUTTON_RELEASE), 32'd1);
        tick(1);
        chk("release_pulse_end", 32'(BUTTON_RELEASE), 32'd0);
        chk("release_count", 32'(rel_cnt - r0), 32'd1);
        chk("release_edge", 32'(rel_edge), 32'(cap + 6));

        // Three-cycle glitch is rejected
        tick(3);
        p0 = press_cnt;
        r0 = rel_cnt;
        PHYSICAL_BUTTON = 1'b1;
        tick(3);
        PHYSICAL_BUTTON = 1'b0;
        tick(15);
        chk("glitch_level", 32'(BUTTON_LEVEL), 32'd0);
        chk("glitch_press", 32'(press_cnt - p0), 32'd0);
        chk("glitch_release", 32'(rel_cnt - r0), 32'd0);

        // Bounce 1,0,1,0,1 then steady high
        p0 = press_cnt;
        PHYSICAL_BUTTON = 1'b1; tick(1);
        PHYSICAL_BUTTON = 1'b0; tick(1);
        PHYSICAL_BUTTON = 1'b1; tick(1);
        PHYSICAL_BUTTON = 1'b0; tick(1);
        PHYSICAL_BUTTON = 1'b1;
        cap = edge_no + 1;
        tick(12);
        chk("bounce_level", 32'(BUTTON_LEVEL), 32'd1);
        chk("bounce_press_count", 32'(press_cnt - p0), 32'd1);
        chk("bounce_press_edge", 32'(press_edge), 32'(cap + 6));
        PHYSICAL_BUTTON = 1'b0;
        tick(12);
        chk("bounce_release_level", 32'(BUTTON_LEVEL), 32'd0);

        // Switches: simultaneous bits then a single bit
        c0 = change_cnt;
        PHYSICAL_SWITCH = 4'b0101;
        tick(12);
        chk("sw_0101", 32'(SWITCH), 32'h5);
        chk("sw_0101_change", 32'(change_cnt - c0), 32'd1);
        PHYSICAL_SWITCH = 4'b1101;
        tick(12);
        chk("sw_1101", 32'(SWITCH), 32'hd);
        chk("sw_1101_change", 32'(change_cnt - c0), 32'd2);

        // Bits settling on consecutive edges give one pulse each
        PHYSICAL_SWITCH = 4'b1100;
        tick(1);
        PHYSICAL_SWITCH = 4'b1000;
        tick(12);
        chk("sw_1000", 32'(SWITCH), 32'h8);
        chk("sw_stagger_change", 32'(change_cnt - c0), 32'd4);

        // Reset during WAIT_HIGH clears outputs immediately
        PHYSICAL_BUTTON = 1'b1;
        tick(4);
        PHYSICAL_RESET = 1'b0;
        #1;
        chk("midreset_RESET", 32'(RESET), 32'd1);
        chk("midreset_outs", outs(), 32'd0);
        PHYSICAL_BUTTON = 1'b0;
        PHYSICAL_SWITCH = 4'd0;
        tick(2);
        p0 = press_cnt;
        c0 = change_cnt;
        PHYSICAL_RESET = 1'b1;
        tick(22);
        chk("midreset_low_RESET", 32'(RESET), 32'd0);
        chk("midreset_low_press", 32'(press_cnt - p0), 32'd0);
        chk("midreset_low_change", 32'(change_cnt - c0), 32'd0);

        // Release with inputs held high: one press, one switch change
        PHYSICAL_RESET = 1'b0;
        tick(1);
        PHYSICAL_BUTTON = 1'b1;
        PHYSICAL_SWITCH = 4'b0011;
        tick(1);
        p0 = press_cnt;
        c0 = change_cnt;
        PHYSICAL_RESET = 1'b1;
        cap = edge_no + 1;
        tick(14);
        chk("midreset_high_press", 32'(press_cnt - p0), 32'd1);
        chk("midreset_high_edge", 32'(press_edge), 32'(cap + 6));
        chk("midreset_high_level", 32'(BUTTON_LEVEL), 32'd1);
        chk("midreset_high_switch", 32'(SWITCH), 32'h3);
        chk("midreset_high_change", 32'(change_cnt - c0), 32'd1);

        chk("press_release_overlap", 32'(overlap_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
